matrix_serializer: RTL

Streams a packed 4x4 matrix out one element per handshake. The matrix comes from the 256-bit flat bus produced by the math modules (scale_matrix and its siblings). The serializer captures the flat word on `start`, then emits its 16 elements in row-major or column-major order over a valid/ready interface, tagged with row/column indices and a last flag. It sits between the matrix math units and any element-wide consumer, such as a memory writer or display/debug port.

---
 rtl/matrix_pkg.sv | 27 ++
 rtl/matrix_index_gen.sv | 49 ++++
 rtl/matrix_serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared 4x4 matrix packing definitions used by the matrix math units, benches and serializer.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
//
// Contents: element width / dimension constants, flat-bus width, element
// offset helper (row-major packing, element (r,c) at c*ELEM_W + r*DIM*ELEM_W),
// and the serializer state enum.
package matrix_pkg;

  localparam int MAT_ELEM_W = 16;
  localparam int MAT_DIM    = 4;
  localparam int MAT_FLAT_W = MAT_DIM * MAT_DIM * MAT_ELEM_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit offset of element (row,col) inside the flat matrix bus.
  function automatic int elem_offset(input int row, input int col,
                                     input int elem_w = MAT_ELEM_W,
                                     input int dim    = MAT_DIM);
    return col * elem_w + row * dim * elem_w;
  endfunction

endpackage

// File: rtl/matrix_index_gen.sv
// Element index generator: k counter, row/col mapping for row- or column-major order, last flag.
// Latency: row/col/last are decoded combinationally from the registered k.
// Backpressure: k only moves on advance, so indices hold while the consumer stalls.
//
// Ports: clk, reset (sync, active-high); clear restarts k at 0; advance steps k;
// col_major selects column-major order; row/col are the current indices;
// last is high when k addresses the final element.
module matrix_index_gen #(
  parameter int DIM = 4,
  localparam int IDX_W = $clog2(DIM),
  localparam int K_W = $clog2(DIM * DIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic             col_major,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic [K_W-1:0] k_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q <= '0;
    end else if (clear) begin
      k_q <= '0;
    end else if (advance) begin
      k_q <= k_q + 1'b1;
    end
  end

  // Upper half of k walks the outer dimension, lower half the inner one;
  // column-major just swaps which half drives row and which drives col.
  always_comb begin
    if (col_major) begin
      row = k_q[IDX_W-1:0];
      col = k_q[K_W-1:IDX_W];
    end else begin
      row = k_q[K_W-1:IDX_W];
      col = k_q[IDX_W-1:0];
    end
  end

  assign last = (k_q == K_W'(DIM * DIM - 1));

endmodule

// File: rtl/matrix_serializer.sv
// Captures a packed DIMxDIM matrix on start and streams its elements one per valid/ready handshake.
// Latency: element 0 valid the cycle after start is sampled; done pulses the cycle after the last handshake.
// Backpressure: elem_valid holds with stable data/indices until elem_ready; any stall length is legal.
//
// Ports: clk, reset (sync, active-high); m_in/start/transpose capture a matrix
// and its order; elem_out/elem_row/elem_col/elem_last/elem_valid/elem_ready form
// the element stream; busy covers SEND and DONE; done is a one-cycle end pulse.
module matrix_serializer #(
  parameter int ELEM_W = matrix_pkg::MAT_ELEM_W,
  parameter int DIM = matrix_pkg::MAT_DIM,
  localparam int FLAT_W = DIM * DIM * ELEM_W,
  localparam int IDX_W = $clog2(DIM),
  localparam int OFF_W = $clog2(FLAT_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAT_W-1:0] m_in,
  input  logic              start,
  input  logic              transpose,
  output logic              busy,
  output logic [ELEM_W-1:0] elem_out,
  output logic [IDX_W-1:0]  elem_row,
  output logic [IDX_W-1:0]  elem_col,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic              elem_last,
  output logic              done
);

  import matrix_pkg::*;

  state_t            state_q, state_d;
  logic [FLAT_W-1:0] capture_q;
  logic              col_major_q;
  logic              load, hs, k_last;
  logic [IDX_W-1:0]  row, col;
  logic [OFF_W-1:0]  off;

  assign load = (state_q == ST_IDLE) && start;
  assign hs   = (state_q == ST_SEND) && elem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SEND;
      ST_SEND: if (hs && k_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: only state and k feed these, never elem_ready.
  always_comb begin
    busy       = 1'b0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_SEND: begin
        busy       = 1'b1;
        elem_valid = 1'b1;
        elem_last  = k_last;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture register and order mode, frozen for the whole stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q   <= '0;
      col_major_q <= 1'b0;
    end else if (load) begin
      capture_q   <= m_in;
      col_major_q <= transpose;
    end
  end

  // k only advances on non-final handshakes, so it sits at the last index
  // through DONE and is cleared again by the next capture.
  matrix_index_gen #(.DIM(DIM)) u_index_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (load),
    .advance   (hs && !k_last),
    .col_major (col_major_q),
    .row       (row),
    .col       (col),
    .last      (k_last)
  );

  assign off      = OFF_W'(elem_offset(int'(row), int'(col), ELEM_W, DIM));
  assign elem_out = capture_q[off +: ELEM_W];
  assign elem_row = row;
  assign elem_col = col;

endmodule
